// File: rtl/otter_cache_pkg.sv
// otter_cache_pkg: cache line geometry and deserializer state encoding shared by fill/write-back paths
package otter_cache_pkg;
  localparam int WORD_W = 32;
  localparam int WORDS_PER_LINE = 8;
  localparam int LINE_W = WORD_W * WORDS_PER_LINE;
  typedef logic [WORDS_PER_LINE-1:0][WORD_W-1:0] line_t;
  typedef enum logic [1:0] {IDLE, COLLECT, DONE} deser_state_t;
endpackage

// File: rtl/deserializer.sv
// deserializer: assembles a stream of memory words into one cache line, word 0 in the low bits
module deserializer
  import otter_cache_pkg::*;
#(
  parameter int WORD_W = otter_cache_pkg::WORD_W,
  parameter int WORDS = otter_cache_pkg::WORDS_PER_LINE,
  localparam int LINE_W = WORD_W * WORDS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              word_valid,
  input  logic [WORD_W-1:0] word_in,
  output logic              word_ready,
  output logic              line_valid,
  input  logic              line_ready,
  output logic [LINE_W-1:0] line_out,
  output logic              busy
);
  localparam int CW = $clog2(WORDS);
  localparam logic [CW-1:0] LAST = CW'(WORDS - 1);
  deser_state_t state;
  logic [CW-1:0] count;
  logic [WORDS-1:0][WORD_W-1:0] line;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      count <= '0;
      line <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state <= COLLECT;
          count <= '0;
        end
        // word_ready is constant high here, so word_valid alone marks an accept
        COLLECT: if (word_valid) begin
          line[count] <= word_in;
          count <= count + 1'b1;
          if (count == LAST) state <= DONE;
        end
        DONE: if (line_ready) begin
          state <= start ? COLLECT : IDLE;
          count <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end
  assign word_ready = state == COLLECT;
  assign line_valid = state == DONE;
  assign busy = state != IDLE;
  assign line_out = line;
endmodule

// File: tb/tb_deserializer.sv
// tb_deserializer: directed checks of fill, gaps, backpressure, back-to-back, async reset and spurious inputs
module tb_deserializer;
  logic clk = 0, rst_n = 0, start = 0, word_valid = 0, line_ready = 0;
  logic [31:0] word_in = '0;
  logic word_ready, line_valid, busy;
  logic [255:0] line_out;
  int checks = 0, errors = 0;
  int lat;
  deserializer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .word_valid(word_valid), .word_in(word_in),
    .word_ready(word_ready), .line_valid(line_valid), .line_ready(line_ready),
    .line_out(line_out), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [255:0] mk(input logic [31:0] base);
    logic [255:0] r;
    for (int k = 0; k < 8; k++) r[k*32 +: 32] = base + 32'(k);
    return r;
  endfunction
  // lat counts edges from the start edge (or from the first word edge without start) to line_valid
  task automatic fill(input logic [31:0] base, input bit do_start, input bit gapped, input int spur, output int n);
    int k, g;
    k = 0;
    g = 0;
    n = 0;
    if (do_start) begin
      start = 1;
      tick();
      start = 0;
      n = 1;
    end
    while (!line_valid && n < 50) begin
      start = (k == spur && g == 0);
      if (g > 0) begin
        word_valid = 0;
        g--;
      end else if (k < 8) begin
        word_valid = 1;
        word_in = base + 32'(k);
      end else word_valid = 0;
      tick();
      n++;
      if (word_valid && k < 8) begin
        k++;
        if (gapped && (k == 3 || k == 6)) g = 3;
      end
    end
    start = 0;
    word_valid = 0;
    if (!line_valid) chk("fill_timeout", 0, 1);
  endtask
  initial begin
    #12;
    chk("rst_word_ready", word_ready, 0);
    chk("rst_line_valid", line_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_line_out", line_out, 0);
    tick();
    rst_n = 1;
    line_ready = 1;
    tick();
    fill(32'h1000_0000, 1, 0, -1, lat);
    chk("basic_latency", lat, 9);
    chk("basic_word0", line_out[31:0], 32'h1000_0000);
    chk("basic_word7", line_out[255:224], 32'h1000_0007);
    chk("basic_line", line_out, mk(32'h1000_0000));
    tick();
    chk("basic_valid_one_cycle", line_valid, 0);
    chk("basic_idle_busy", busy, 0);
    line_ready = 0;
    fill(32'h1000_0000, 1, 1, -1, lat);
    chk("gap_latency", lat, 15);
    chk("gap_line", line_out, mk(32'h1000_0000));
    word_valid = 1;
    word_in = 32'hDEAD_BEEF;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_word_ready", word_ready, 0);
      chk("bp_line_valid", line_valid, 1);
      chk("bp_line_out", line_out, mk(32'h1000_0000));
    end
    line_ready = 1;
    tick();
    word_valid = 0;
    chk("bp_release_busy", busy, 0);
    line_ready = 0;
    fill(32'h3000_0000, 1, 0, -1, lat);
    chk("b2b_first_line", line_out, mk(32'h3000_0000));
    line_ready = 1;
    start = 1;
    tick();
    start = 0;
    chk("b2b_collect", word_ready, 1);
    chk("b2b_first_intact", line_out, mk(32'h3000_0000));
    fill(32'h2000_0000, 0, 0, -1, lat);
    chk("b2b_latency", lat, 8);
    chk("b2b_second_line", line_out, mk(32'h2000_0000));
    tick();
    fill(32'h6000_0000, 1, 0, 3, lat);
    chk("spur_latency", lat, 9);
    chk("spur_line", line_out, mk(32'h6000_0000));
    tick();
    word_valid = 1;
    word_in = 32'h0000_0BAD;
    tick();
    tick();
    word_valid = 0;
    chk("idle_word_ignored", line_out, mk(32'h6000_0000));
    chk("idle_word_busy", busy, 0);
    start = 1;
    tick();
    start = 0;
    for (int i = 0; i < 4; i++) begin
      word_valid = 1;
      word_in = 32'h7000_0000 + 32'(i);
      tick();
    end
    word_valid = 0;
    #2 rst_n = 0;
    #1;
    chk("async_rst_busy", busy, 0);
    chk("async_rst_word_ready", word_ready, 0);
    chk("async_rst_line_valid", line_valid, 0);
    chk("async_rst_line_out", line_out, 0);
    tick();
    rst_n = 1;
    tick();
    fill(32'h5000_0000, 1, 0, -1, lat);
    chk("post_rst_latency", lat, 9);
    chk("post_rst_line", line_out, mk(32'h5000_0000));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
